mvm_acc_act: RTL and testbench



---
 rtl/mvm_acc_act.sv | 137 +++++++++++++
 tb/tb_mvm_acc_act.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_acc_act.sv
// Accumulates N_TERMS stochastic-MVM lane results per output and applies a sign activation.
// Optional MVM_ACC_SAT_EN: saturate on overflow instead of wrapping.
module mvm_acc_act #(
    parameter int N_LANE  = 4,
    parameter int IN_W    = 4,
    parameter int ACC_W   = 10,
    parameter int N_TERMS = 8
) (
    input  logic              i_clk_acc,
    input  logic              i_rst_acc,
    input  logic              i_ismvm,
    input  logic [IN_W-1:0]   i_wx_result [N_LANE-1:0],
    input  logic              i_clr_acc,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ACC_W-1:0]  o_acc [N_LANE-1:0],
    output logic [N_LANE-1:0] o_act,
    output logic              o_stall,
    output logic              o_drop,
    output logic [N_LANE-1:0] o_ovf
);

    typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, OUT = 2'd2} state_t;

    localparam logic [7:0] LAST = 8'(N_TERMS);

    state_t             state_q, state_d;
    logic               ismvm_dly_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         cnt_inc;
    logic [ACC_W-1:0]   acc_q [N_LANE-1:0];
    logic [ACC_W-1:0]   acc_d [N_LANE-1:0];
    logic [ACC_W-1:0]   lane_nxt [N_LANE-1:0];
    logic [N_LANE-1:0]  lane_ovf;
    logic [N_LANE-1:0]  ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               drop_q, drop_d;
    logic               cap;
    logic               last_term;

    // End of a generation window: busy was high last cycle and is low now.
    assign cap       = ismvm_dly_q & ~i_ismvm;
    assign cnt_inc   = cnt_q + 8'd1;
    assign last_term = (cnt_inc == LAST);

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        logic [ACC_W:0] sum;
        assign sum = {acc_q[i][ACC_W-1], acc_q[i]}
                   + {{(ACC_W+1-IN_W){i_wx_result[i][IN_W-1]}}, i_wx_result[i]};
        assign lane_ovf[i] = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef MVM_ACC_SAT_EN
        // sum[ACC_W] carries the sign of the true result, so it picks the rail.
        assign lane_nxt[i] = !lane_ovf[i] ? sum[ACC_W-1:0] :
                             sum[ACC_W]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                            {1'b0, {(ACC_W-1){1'b1}}};
`else
        assign lane_nxt[i] = sum[ACC_W-1:0];
`endif
        assign o_acc[i] = acc_q[i];
        assign o_act[i] = ~acc_q[i][ACC_W-1];
    end

    always_ff @(posedge i_clk_acc or negedge i_rst_acc) begin
        if (!i_rst_acc) begin
            state_q     <= IDLE;
            ismvm_dly_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '{default: '0};
            ovf_q       <= '0;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ismvm_dly_q <= i_ismvm;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clr_acc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (i_ismvm) state_d = GEN;
                GEN:     if (cap) state_d = last_term ? OUT : IDLE;
                OUT:     if (i_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        if (i_clr_acc) begin
            // Clear wins over a same-cycle capture or transfer; that capture is not a drop.
            cnt_d   = '0;
            acc_d   = '{default: '0};
            ovf_d   = '0;
            valid_d = 1'b0;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                GEN: if (cap) begin
                    acc_d = lane_nxt;
                    ovf_d = ovf_q | lane_ovf;
                    cnt_d = cnt_inc;
                    if (last_term) valid_d = 1'b1;
                end
                OUT: begin
                    if (cap) drop_d = 1'b1;
                    if (i_ready) begin
                        cnt_d   = '0;
                        acc_d   = '{default: '0};
                        ovf_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_stall = (state_q == OUT);
    assign o_drop  = drop_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_mvm_acc_act.sv
// Directed/random bench for mvm_acc_act: a 10-bit instance for the main datapath and a
// 6-bit instance sharing all control inputs for overflow behaviour.
module tb_mvm_acc_act;

    localparam int NT   = 8;
    localparam int AW_A = 10;
    localparam int AW_B = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ismvm = 1'b0;
    logic       clr = 1'b0;
    logic       ready = 1'b1;
    logic [3:0] wx_a [3:0];
    logic [3:0] wx_b [3:0];

    logic            valid_a, stall_a, drop_a, valid_b, stall_b, drop_b;
    logic [AW_A-1:0] acc_a [3:0];
    logic [AW_B-1:0] acc_b [3:0];
    logic [3:0]      act_a, ovf_a, act_b, ovf_b;

    always #5 clk = ~clk;

    mvm_acc_act #(.N_LANE(4), .IN_W(4), .ACC_W(AW_A), .N_TERMS(NT)) dut_a (
        .i_clk_acc(clk), .i_rst_acc(rst_n), .i_ismvm(ismvm), .i_wx_result(wx_a),
        .i_clr_acc(clr), .i_ready(ready), .o_valid(valid_a), .o_acc(acc_a),
        .o_act(act_a), .o_stall(stall_a), .o_drop(drop_a), .o_ovf(ovf_a));

    mvm_acc_act #(.N_LANE(4), .IN_W(4), .ACC_W(AW_B), .N_TERMS(NT)) dut_b (
        .i_clk_acc(clk), .i_rst_acc(rst_n), .i_ismvm(ismvm), .i_wx_result(wx_b),
        .i_clr_acc(clr), .i_ready(ready), .o_valid(valid_b), .o_acc(acc_b),
        .o_act(act_b), .o_stall(stall_b), .o_drop(drop_b), .o_ovf(ovf_b));

    int n_cmp = 0;
    int n_err = 0;

    // Reference: true stored lane values, sticky overflow, terms taken, output pending, drop.
    int m_a [4];
    int m_b [4];
    bit ov_a [4];
    bit ov_b [4];
    int m_cnt;
    bit m_out;
    bit m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int fold(input int cur, input int x, input int w, output bit ov);
        int s, mx, mn;
        s  = cur + x;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        ov = (s > mx) || (s < mn);
        if (!ov) return s;
`ifdef MVM_ACC_SAT_EN
        return (s > mx) ? mx : mn;
`else
        return (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
    endfunction

    task automatic m_clear_sums();
        for (int i = 0; i < 4; i++) begin
            m_a[i] = 0; m_b[i] = 0; ov_a[i] = 0; ov_b[i] = 0;
        end
        m_cnt = 0;
        m_out = 0;
    endtask

    task automatic m_capture(input logic [15:0] va, input logic [15:0] vb);
        bit o;
        int x;
        if (m_out) begin
            m_drop = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                x = int'($signed(va[4*i +: 4]));
                m_a[i] = fold(m_a[i], x, AW_A, o);
                ov_a[i] = ov_a[i] | o;
                x = int'($signed(vb[4*i +: 4]));
                m_b[i] = fold(m_b[i], x, AW_B, o);
                ov_b[i] = ov_b[i] | o;
            end
            m_cnt++;
            if (m_cnt == NT) m_out = 1;
        end
    endtask

    task automatic check_out(input string tag);
        logic [3:0] ea, eb, oa, ob;
        for (int i = 0; i < 4; i++) begin
            ea[i] = (m_a[i] >= 0); eb[i] = (m_b[i] >= 0);
            oa[i] = ov_a[i];       ob[i] = ov_b[i];
            chk($sformatf("%s.acc_a%0d", tag, i), 32'(acc_a[i]), 32'(m_a[i]) & 32'h3FF);
            chk($sformatf("%s.acc_b%0d", tag, i), 32'(acc_b[i]), 32'(m_b[i]) & 32'h3F);
        end
        chk({tag, ".act_a"}, 32'(act_a), 32'(ea));
        chk({tag, ".act_b"}, 32'(act_b), 32'(eb));
        chk({tag, ".ovf_a"}, 32'(ovf_a), 32'(oa));
        chk({tag, ".ovf_b"}, 32'(ovf_b), 32'(ob));
        chk({tag, ".valid"}, {30'd0, valid_a, valid_b}, {30'd0, m_out, m_out});
        chk({tag, ".stall"}, {30'd0, stall_a, stall_b}, {30'd0, m_out, m_out});
        chk({tag, ".drop"},  {30'd0, drop_a, drop_b},   {30'd0, m_drop, m_drop});
    endtask

    // One-cycle busy pulse; lane values held through the capture edge. Returns on a negedge.
    task automatic window(input logic [15:0] va, input logic [15:0] vb, input bit with_clr);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wx_a[i] = va[4*i +: 4];
            wx_b[i] = vb[4*i +: 4];
        end
        ismvm = 1'b1;
        @(negedge clk);
        ismvm = 1'b0;
        clr = with_clr;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_group(input string tag, input int n);
        logic [15:0] va, vb;
        for (int k = 0; k < n; k++) begin
            va = 16'($urandom);
            vb = 16'($urandom);
            window(va, vb, 1'b0);
            m_capture(va, vb);
            check_out($sformatf("%s.w%0d", tag, k));
        end
    endtask

    // With ready high, the edge after the output cycle performs the transfer.
    task automatic xfer_step(input string tag);
        @(negedge clk);
        m_clear_sums();
        check_out(tag);
    endtask

    initial begin
        logic [15:0] va, vb;
        for (int i = 0; i < 4; i++) begin
            wx_a[i] = 4'h0; wx_b[i] = 4'h0;
        end
        m_clear_sums();
        m_drop = 0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_out("rst");
        chk("rst.act_const", 32'(act_a), 32'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                wx_a[i] = 4'($urandom); wx_b[i] = 4'($urandom);
            end
        end
        @(negedge clk);
        check_out("idle_toggle");

        // Basic accumulate: A lanes {+3,-2,0,-8}; B lane0 = +7 to overflow 6 bits
        va = 16'h80E3;
        for (int k = 0; k < NT; k++) begin
            vb = {12'($urandom), 4'h7};
            window(va, vb, 1'b0);
            m_capture(va, vb);
            check_out($sformatf("basic.w%0d", k));
        end
        chk("basic.acc0", 32'(acc_a[0]), 32'd24);
        chk("basic.acc1", 32'(acc_a[1]), 32'h3F0);
        chk("basic.acc2", 32'(acc_a[2]), 32'd0);
        chk("basic.acc3", 32'(acc_a[3]), 32'h3C0);
        chk("basic.act",  32'(act_a),    32'b0101);
`ifdef MVM_ACC_SAT_EN
        chk("ovf.acc_b0", 32'(acc_b[0]), 32'h1F);
`else
        chk("ovf.acc_b0", 32'(acc_b[0]), 32'h38);
`endif
        chk("ovf.flag_b0", 32'(ovf_b[0]), 32'd1);
        xfer_step("basic.xfer");

        // Random accumulate
        run_group("rand", NT);
        xfer_step("rand.xfer");

        // Backpressure: output held, extra window dropped
        ready = 1'b0;
        run_group("bp", NT);
        va = 16'($urandom);
        vb = 16'($urandom);
        window(va, vb, 1'b0);
        m_capture(va, vb);
        check_out("bp.extra");
        @(negedge clk);
        check_out("bp.hold");
        ready = 1'b1;
        xfer_step("bp.xfer");

        // Clear on the 5th capture
        run_group("clr", 4);
        window(16'($urandom), 16'($urandom), 1'b1);
        m_clear_sums();
        m_drop = 0;
        check_out("clr.after");
        run_group("clr.clean", NT);
        xfer_step("clr.xfer");

        // Asynchronous reset between edges while in GEN
        run_group("arst", 3);
        @(negedge clk);
        ismvm = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ismvm = 1'b0;
        #1;
        m_clear_sums();
        m_drop = 0;
        check_out("arst.async");
        @(negedge clk);
        rst_n = 1'b1;
        check_out("arst.release");
        run_group("arst.clean", NT);
        xfer_step("arst.xfer");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
